// File: rtl/dmem_uart_tx_if.sv
// Processor data-memory port as seen by the memory-mapped UART transmitter.
//   we    : write strobe
//   a     : byte address
//   wd    : write data
//   rd    : read data returned by the responder (0 when not addressed)
//   o_hit : responder decodes the current address into its window
// master: processor side; slave: UART side.
interface dmem_uart_tx_if;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        o_hit;

   modport master (output we, a, wd, input rd, o_hit);
   modport slave  (input we, a, wd, output rd, o_hit);
endinterface

// File: rtl/dmem_uart_tx.sv
// Memory-mapped UART transmitter on the processor data-memory port.
// Stores to TXDATA are queued in a FIFO and serialized LSB first on o_tx
// (8N1 by default, 8E1 when DMEM_UART_TX_PARITY_EN is defined).
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   bus    : data-memory port (slave modport): we, a, wd in; rd, o_hit out
//   o_tx   : serial line, idle high, registered
//   o_busy : registered, FSM not idle or FIFO not empty
// Register map (offset a[3:2]): 0 TXDATA, 1 STATUS {cnt[3:0],ovf,busy,empty,full}.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (high); chains into START if more bytes are queued
module dmem_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rst,
   dmem_uart_tx_if.slave    bus,
   output logic             o_tx,
   output logic             o_busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t         state, state_next;
   logic [BW-1:0]  baud;
   logic [2:0]     bit_idx;
   logic [7:0]     shifter;
   logic           par;
   logic           baud_last;
   logic           pop, tx_d, busy_d;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count, count_next;
   logic           full, empty, ovf;

   logic [1:0]     offset;
   logic           wr_data, wr_stat, push, ovf_set;
   logic [8:0]     cnt_wide;
   logic [3:0]     cnt_sat;
   logic           unused_bits;

   // ---------------- address decode ----------------
   assign offset      = bus.a[3:2];
   assign bus.o_hit   = (bus.a[31:4] == BASE_ADDR[31:4]);
   assign wr_data     = bus.we && bus.o_hit && (offset == 2'd0);
   assign wr_stat     = bus.we && bus.o_hit && (offset == 2'd1);
   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign push        = wr_data && !full;
   assign ovf_set     = wr_data && full;
   assign unused_bits = ^{bus.wd[31:8], bus.a[1:0]};

   assign cnt_wide = 9'(count);
   assign cnt_sat  = (cnt_wide > 9'd15) ? 4'hF : cnt_wide[3:0];

   always_comb begin
      bus.rd = 32'h0;
      if (bus.o_hit && offset == 2'd1)
         bus.rd = {24'h0, cnt_sat, ovf, o_busy, empty, full};
   end

   // ---------------- FIFO ----------------
   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.wd[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         // a dropped push wins over a simultaneous clear
         if (ovf_set)
            ovf <= 1'b1;
         else if (wr_stat && bus.wd[3])
            ovf <= 1'b0;
      end
   end

   // ---------------- FSM: state register ----------------
   assign baud_last = (baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_idx <= 3'd0;
         shifter <= 8'h0;
         par     <= 1'b0;
         o_tx    <= 1'b1;
         o_busy  <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state || state == S_IDLE || baud_last)
            baud <= '0;
         else
            baud <= baud + 1'b1;
         if (state != S_DATA)
            bit_idx <= 3'd0;
         else if (baud_last)
            bit_idx <= bit_idx + 3'd1;
         if (pop) begin
            shifter <= mem[rd_ptr];
            par     <= ^mem[rd_ptr];
         end else if (state == S_DATA && baud_last) begin
            shifter <= shifter >> 1;
         end
         o_tx   <= tx_d;
         o_busy <= busy_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (!empty) state_next = S_START;
         S_START:  if (baud_last) state_next = S_DATA;
         S_DATA:
            if (baud_last && bit_idx == 3'd7) begin
`ifdef DMEM_UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         S_PARITY: if (baud_last) state_next = S_STOP;
         S_STOP:   if (baud_last) state_next = empty ? S_IDLE : S_START;
         default:  state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // o_tx is registered, so the value for the next state is chosen here;
   // at a bit boundary inside DATA the next bit is shifter[1].
   always_comb begin
      pop    = !empty && (state == S_IDLE || (state == S_STOP && baud_last));
      busy_d = (state_next != S_IDLE) || (count_next != '0);
      case (state_next)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = (state == S_DATA && baud_last) ? shifter[1] : shifter[0];
         S_PARITY: tx_d = par;
         default:  tx_d = 1'b1;
      endcase
   end

endmodule
